// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and grant encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    D_WACK = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } arb_gnt_t;

  // Streak counter width; MAX_D_BURST is limited to 1..15.
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data has priority; a streak limit guarantees fetch progress.
//
// state  | meaning
// IDLE   | arbitrate; a grant issues m_req in this same cycle
// I_WAIT | fetch outstanding, waiting for m_data_valid
// D_WAIT | load outstanding, waiting for m_data_valid
// D_WACK | store accepted at issue edge, pulse d_data_valid once
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_data_read,
  output logic                    i_data_valid,
  input  logic                    d_req,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_data_write,
  input  logic [DATA_WIDTH/8-1:0] d_data_wstrb,
  input  logic                    d_write_enable,
  output logic [DATA_WIDTH-1:0]   d_data_read,
  output logic                    d_data_valid,
  output logic                    m_req,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [DATA_WIDTH-1:0]   m_data_write,
  output logic [DATA_WIDTH/8-1:0] m_data_wstrb,
  output logic                    m_write_enable,
  input  logic [DATA_WIDTH-1:0]   m_data_read,
  input  logic                    m_data_valid
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_BURST);

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;
  arb_gnt_t            w_gnt;
  logic                w_starve;
  logic                w_i_ret;
  logic                w_d_ret;

  assign w_starve = i_req && (r_streak == MAX_STREAK);

  always_comb begin
    w_gnt = GNT_NONE;
    if (r_state == IDLE) begin
      if (d_req && !w_starve) w_gnt = GNT_D;
      else if (i_req)         w_gnt = GNT_I;
    end
  end

  always_comb begin
    m_req          = 1'b0;
    m_address      = '0;
    m_data_write   = '0;
    m_data_wstrb   = '0;
    m_write_enable = 1'b0;
    case (w_gnt)
      GNT_I: begin
        m_req     = 1'b1;
        m_address = i_address;
      end
      GNT_D: begin
        m_req          = 1'b1;
        m_address      = d_address;
        m_data_write   = d_data_write;
        m_data_wstrb   = d_data_wstrb;
        m_write_enable = d_write_enable;
      end
      default: ;
    endcase
  end

  // Read data is forwarded straight through in the return cycle, zero otherwise.
  assign w_i_ret      = (r_state == I_WAIT) && m_data_valid;
  assign w_d_ret      = (r_state == D_WAIT) && m_data_valid;
  assign i_data_valid = w_i_ret;
  assign i_data_read  = w_i_ret ? m_data_read : '0;
  assign d_data_valid = w_d_ret || (r_state == D_WACK);
  assign d_data_read  = w_d_ret ? m_data_read : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          case (w_gnt)
            GNT_I: begin
              r_state  <= I_WAIT;
              r_streak <= '0;
            end
            GNT_D: begin
              r_state <= d_write_enable ? D_WACK : D_WAIT;
              if (!i_req)                    r_streak <= '0;
              else if (r_streak != MAX_STREAK) r_streak <= r_streak + 1'b1;
            end
            default: if (!i_req) r_streak <= '0;
          endcase
        end
        I_WAIT: if (m_data_valid) r_state <= IDLE;
        D_WAIT: if (m_data_valid) r_state <= IDLE;
        D_WACK: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, requester tasks and
// issue/completion scoreboards compared per scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_data_read;
  logic        i_data_valid;
  logic        d_req = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_data_write = '0;
  logic [3:0]  d_data_wstrb = '0;
  logic        d_write_enable = 1'b0;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  logic        m_req;
  logic [31:0] m_address;
  logic [31:0] m_data_write;
  logic [3:0]  m_data_wstrb;
  logic        m_write_enable;
  logic [31:0] m_data_read;
  logic        m_data_valid;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address), .i_data_read(i_data_read), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_address(d_address), .d_data_write(d_data_write), .d_data_wstrb(d_data_wstrb),
    .d_write_enable(d_write_enable), .d_data_read(d_data_read), .d_data_valid(d_data_valid),
    .m_req(m_req), .m_address(m_address), .m_data_write(m_data_write), .m_data_wstrb(m_data_wstrb),
    .m_write_enable(m_write_enable), .m_data_read(m_data_read), .m_data_valid(m_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } cpl_t;

  issue_t      obs_issue[$];
  issue_t      exp_issue[$];
  cpl_t        obs_i[$];
  cpl_t        obs_d[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_idle_read = 0;

  logic [31:0] mem [0:1023];
  int          rd_lat = 1;
  int          rd_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic        extra_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT output events at the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_req) begin
        issue_t t;
        t.cyc = cyc; t.addr = m_address; t.we = m_write_enable;
        t.strb = m_data_wstrb; t.wdata = m_data_write;
        obs_issue.push_back(t);
      end
      if (i_data_valid) begin
        cpl_t c;
        c.cyc = cyc; c.data = i_data_read;
        obs_i.push_back(c);
      end
      if (d_data_valid) begin
        cpl_t c;
        c.cyc = cyc; c.data = d_data_read;
        obs_d.push_back(c);
      end
      if ((!i_data_valid && i_data_read != 32'h0) || (!d_data_valid && d_data_read != 32'h0))
        bad_idle_read++;
    end
  end

  // Behavioural memory: strobed writes at issue, reads return rd_lat cycles later.
  initial begin
    m_data_valid = 1'b0;
    m_data_read  = '0;
    forever begin
      @(negedge clk);
      if (reset_n && m_req) begin
        if (m_write_enable) begin
          for (int b = 0; b < 4; b++)
            if (m_data_wstrb[b]) mem[m_address[11:2]][8*b +: 8] = m_data_write[8*b +: 8];
        end else begin
          rd_cnt  = rd_lat;
          rd_addr = m_address;
        end
      end
      @(posedge clk);
      #1;
      m_data_valid = 1'b0;
      m_data_read  = '0;
      if (rd_cnt == 1) begin
        m_data_valid = 1'b1;
        m_data_read  = mem[rd_addr[11:2]];
      end else if (extra_valid) begin
        m_data_valid = 1'b1;
        m_data_read  = 32'hBAD0BAD0;
        extra_valid  = 1'b0;
      end
      if (rd_cnt > 0) rd_cnt--;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic clear_sb();
    obs_issue.delete(); exp_issue.delete();
    obs_i.delete(); obs_d.delete(); exp_i.delete(); exp_d.delete();
  endtask

  task automatic push_issue(input logic [31:0] a, input logic we, input logic [3:0] st, input logic [31:0] wd);
    issue_t t;
    t.cyc = 0; t.addr = a; t.we = we; t.strb = st; t.wdata = wd;
    exp_issue.push_back(t);
  endtask

  task automatic fetch_req(input logic [31:0] a, input logic [31:0] exp_rd);
    int n = 0;
    i_address = a;
    i_req     = 1'b1;
    exp_i.push_back(exp_rd);
    do begin @(negedge clk); n++; end while (!i_data_valid && n < 40);
    n_checks++;
    if (!i_data_valid) begin
      n_fail++;
      $display("FAIL fetch_timeout addr=%h: i_data_valid=0 after %0d cycles, required 1", a, n);
    end
    @(posedge clk); #1;
    i_req = 1'b0; i_address = '0;
  endtask

  task automatic data_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] exp_rd);
    int n = 0;
    d_address = a; d_write_enable = we; d_data_write = wd; d_data_wstrb = st;
    d_req = 1'b1;
    exp_d.push_back(exp_rd);
    do begin @(negedge clk); n++; end while (!d_data_valid && n < 40);
    n_checks++;
    if (!d_data_valid) begin
      n_fail++;
      $display("FAIL data_timeout addr=%h: d_data_valid=0 after %0d cycles, required 1", a, n);
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_address = '0; d_write_enable = 1'b0; d_data_write = '0; d_data_wstrb = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_req, m_write_enable, i_data_valid, d_data_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 0000", {m_req, m_write_enable, i_data_valid, d_data_valid});
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_address, m_data_write, m_data_wstrb} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h strb=%b, required all 0", m_address, m_data_write, m_data_wstrb);
    end
    n_checks++;
    if ({i_data_read, d_data_read, i_data_valid, d_data_valid} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_returns: i=%h d=%h iv=%b dv=%b, required all 0", i_data_read, d_data_read, i_data_valid, d_data_valid);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_issue.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_mreq: got %0d issues, required 0", obs_issue.size());
    end
  endtask

  task automatic test_fetch();
    issue_t ei, oi;
    cpl_t   oc;
    logic [31:0] ed;
    clear_sb();
    push_issue(32'h40, 1'b0, 4'h0, 32'h0);
    fetch_req(32'h40, 32'h0000_0013);
    push_issue(32'h44, 1'b0, 4'h0, 32'h0);
    fetch_req(32'h44, 32'hA5A5_0001);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_i.size() == 0 || obs_issue.size() == 0 || obs_i[0].cyc != obs_issue[0].cyc + 1) begin
      n_fail++;
      $display("FAIL fetch_latency: i_valid %0d/issue %0d entries, required valid exactly 1 cycle after issue",
               obs_i.size(), obs_issue.size());
    end
    while (exp_issue.size() != 0) begin
      ei = exp_issue.pop_front();
      n_checks++;
      if (obs_issue.size() == 0) begin
        n_fail++; $display("FAIL fetch_issue: no m_req seen, required addr=%h", ei.addr);
      end else begin
        oi = obs_issue.pop_front();
        if (oi.addr !== ei.addr || oi.we !== ei.we) begin
          n_fail++; $display("FAIL fetch_issue: addr=%h we=%b, required addr=%h we=%b", oi.addr, oi.we, ei.addr, ei.we);
        end
      end
    end
    n_checks++;
    if (obs_issue.size() != 0) begin
      n_fail++; $display("FAIL fetch_extra_mreq: %0d extra issues, required 0", obs_issue.size());
    end
    while (exp_i.size() != 0) begin
      ed = exp_i.pop_front();
      n_checks++;
      if (obs_i.size() == 0) begin
        n_fail++; $display("FAIL fetch_data: no i_data_valid, required %h", ed);
      end else begin
        oc = obs_i.pop_front();
        if (oc.data !== ed) begin
          n_fail++; $display("FAIL fetch_data: got %h, required %h", oc.data, ed);
        end
      end
    end
    n_checks++;
    if (obs_i.size() != 0 || obs_d.size() != 0) begin
      n_fail++; $display("FAIL fetch_stray_valid: i extra %0d d %0d, required 0 and 0", obs_i.size(), obs_d.size());
    end
  endtask

  task automatic test_priority();
    issue_t ei, oi;
    cpl_t   oc;
    logic [31:0] ed;
    clear_sb();
    push_issue(32'h100, 1'b0, 4'h0, 32'h0);
    push_issue(32'h40,  1'b0, 4'h0, 32'h0);
    fork
      data_req(32'h100, 1'b0, 32'h0, 4'h0, 32'hCAFE_0100);
      fetch_req(32'h40, 32'h0000_0013);
    join
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_d.size() == 0 || obs_i.size() == 0 || obs_d[0].cyc >= obs_i[0].cyc) begin
      n_fail++; $display("FAIL prio_order: d entries %0d i entries %0d, required load completion before fetch",
                         obs_d.size(), obs_i.size());
    end
    while (exp_issue.size() != 0) begin
      ei = exp_issue.pop_front();
      n_checks++;
      if (obs_issue.size() == 0) begin
        n_fail++; $display("FAIL prio_issue: no m_req seen, required addr=%h", ei.addr);
      end else begin
        oi = obs_issue.pop_front();
        if (oi.addr !== ei.addr || oi.we !== ei.we) begin
          n_fail++; $display("FAIL prio_issue: addr=%h we=%b, required addr=%h we=%b", oi.addr, oi.we, ei.addr, ei.we);
        end
      end
    end
    ed = exp_d.pop_front();
    n_checks++;
    if (obs_d.size() == 0) begin
      n_fail++; $display("FAIL prio_load_data: none, required %h", ed);
    end else begin
      oc = obs_d.pop_front();
      if (oc.data !== ed) begin
        n_fail++; $display("FAIL prio_load_data: got %h, required %h", oc.data, ed);
      end
    end
    ed = exp_i.pop_front();
    n_checks++;
    if (obs_i.size() == 0) begin
      n_fail++; $display("FAIL prio_fetch_data: none, required %h", ed);
    end else begin
      oc = obs_i.pop_front();
      if (oc.data !== ed) begin
        n_fail++; $display("FAIL prio_fetch_data: got %h, required %h", oc.data, ed);
      end
    end
  endtask

  task automatic test_store();
    issue_t ei, oi;
    cpl_t   oc;
    logic [31:0] ed;
    clear_sb();
    push_issue(32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    data_req(32'h200, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0);
    push_issue(32'h200, 1'b0, 4'h0, 32'h0);
    data_req(32'h200, 1'b0, 32'h0, 4'h0, 32'h1122_BEEF);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_d.size() == 0 || obs_issue.size() == 0 || obs_d[0].cyc != obs_issue[0].cyc + 1) begin
      n_fail++; $display("FAIL store_ack_latency: d %0d issue %0d entries, required ack 1 cycle after issue",
                         obs_d.size(), obs_issue.size());
    end
    while (exp_issue.size() != 0) begin
      ei = exp_issue.pop_front();
      n_checks++;
      if (obs_issue.size() == 0) begin
        n_fail++; $display("FAIL store_issue: no m_req seen, required addr=%h", ei.addr);
      end else begin
        oi = obs_issue.pop_front();
        if (oi.addr !== ei.addr || oi.we !== ei.we ||
            (ei.we && (oi.strb !== ei.strb || oi.wdata !== ei.wdata))) begin
          n_fail++; $display("FAIL store_issue: addr=%h we=%b strb=%b wd=%h, required addr=%h we=%b strb=%b wd=%h",
                             oi.addr, oi.we, oi.strb, oi.wdata, ei.addr, ei.we, ei.strb, ei.wdata);
        end
      end
    end
    while (exp_d.size() != 0) begin
      ed = exp_d.pop_front();
      n_checks++;
      if (obs_d.size() == 0) begin
        n_fail++; $display("FAIL store_return: none, required %h", ed);
      end else begin
        oc = obs_d.pop_front();
        if (oc.data !== ed) begin
          n_fail++; $display("FAIL store_return: got %h, required %h", oc.data, ed);
        end
      end
    end
    n_checks++;
    if (obs_d.size() != 0 || obs_i.size() != 0) begin
      n_fail++; $display("FAIL store_stray_valid: d extra %0d i %0d, required 0 and 0", obs_d.size(), obs_i.size());
    end
  endtask

  task automatic test_back_to_back();
    issue_t ei, oi;
    cpl_t   oc;
    logic [31:0] ed;
    int k = 0;
    clear_sb();
    for (int j = 0; j < 4; j++) push_issue(32'h300 + 32'(4*j), 1'b0, 4'h0, 32'h0);
    push_issue(32'h40,  1'b0, 4'h0, 32'h0);
    push_issue(32'h310, 1'b0, 4'h0, 32'h0);
    fork
      begin
        for (int j = 0; j < 5; j++)
          data_req(32'h300 + 32'(4*j), 1'b0, 32'h0, 4'h0, 32'h5000_0000 + 32'(j));
      end
      fetch_req(32'h40, 32'h0000_0013);
    join
    repeat (2) @(posedge clk);
    #1;
    while (exp_issue.size() != 0) begin
      ei = exp_issue.pop_front();
      n_checks++;
      if (obs_issue.size() == 0) begin
        n_fail++; $display("FAIL burst_issue[%0d]: no m_req seen, required addr=%h", k, ei.addr);
      end else begin
        oi = obs_issue.pop_front();
        if (oi.addr !== ei.addr || oi.we !== ei.we) begin
          n_fail++; $display("FAIL burst_issue[%0d]: addr=%h, required addr=%h", k, oi.addr, ei.addr);
        end
      end
      k++;
    end
    while (exp_d.size() != 0) begin
      ed = exp_d.pop_front();
      n_checks++;
      if (obs_d.size() == 0) begin
        n_fail++; $display("FAIL burst_load_data: none, required %h", ed);
      end else begin
        oc = obs_d.pop_front();
        if (oc.data !== ed) begin
          n_fail++; $display("FAIL burst_load_data: got %h, required %h", oc.data, ed);
        end
      end
    end
    ed = exp_i.pop_front();
    n_checks++;
    if (obs_i.size() == 0 || obs_i[0].data !== ed) begin
      n_fail++; $display("FAIL burst_fetch_data: %0d entries, required one with %h", obs_i.size(), ed);
    end
  endtask

  task automatic test_reset_mid_fetch();
    cpl_t oc;
    clear_sb();
    rd_lat = 5;
    i_address = 32'h48;
    i_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    i_req = 1'b0; i_address = '0;
    rd_cnt = 0;
    @(negedge clk);
    n_checks++;
    if ({m_req, i_data_valid, d_data_valid} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_outputs: m_req/iv/dv=%b, required 000", {m_req, i_data_valid, d_data_valid});
    end
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    extra_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_i.size() != 0 || obs_d.size() != 0) begin
      n_fail++; $display("FAIL midreset_no_valid: i %0d d %0d pulses, required 0 and 0", obs_i.size(), obs_d.size());
    end
    n_checks++;
    if (obs_issue.size() != 1 || obs_issue[0].addr !== 32'h48) begin
      n_fail++; $display("FAIL midreset_issue: %0d issues, required only the pre-reset fetch at 00000048", obs_issue.size());
    end
    clear_sb();
    rd_lat = 1;
    fetch_req(32'h44, 32'hA5A5_0001);
    #1;
    n_checks++;
    if (obs_i.size() == 0) begin
      n_fail++; $display("FAIL midreset_recover: no fetch return, required %h", 32'hA5A5_0001);
    end else begin
      oc = obs_i.pop_front();
      if (oc.data !== 32'hA5A5_0001) begin
        n_fail++; $display("FAIL midreset_recover: got %h, required %h", oc.data, 32'hA5A5_0001);
      end
    end
  endtask

  task automatic test_idle_read_zero();
    n_checks++;
    if (bad_idle_read != 0) begin
      n_fail++; $display("FAIL read_bus_idle: %0d cycles with nonzero read data outside valid, required 0", bad_idle_read);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[32'h40 >> 2]  = 32'h0000_0013;
    mem[32'h44 >> 2]  = 32'hA5A5_0001;
    mem[32'h48 >> 2]  = 32'h7777_0048;
    mem[32'h100 >> 2] = 32'hCAFE_0100;
    mem[32'h200 >> 2] = 32'h1122_3344;
    for (int j = 0; j < 5; j++) mem[(32'h300 >> 2) + j] = 32'h5000_0000 + 32'(j);
    #1;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_back_to_back();
    test_reset_mid_fetch();
    test_idle_read_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory (RAM with rdata_valid return) between the RISC core's instruction-fetch port and its load/store port. It replaces the separate ROM/RAM pair, so program and data live in one array. Data accesses have priority, with a starvation limit that guarantees instruction-fetch progress. The block sits between RISC and the memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of all address buses
DATA_WIDTH, 32, data bus width; strobe width is DATA_WIDTH/8
MAX_D_BURST, 4, max consecutive data grants while i_req is pending (legal range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
i_req  in  1  instruction fetch request, held until i_data_valid
i_address  in  ADDR_WIDTH  fetch address, stable while i_req
i_data_read  out  DATA_WIDTH  fetched instruction
i_data_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_data_valid
d_address  in  ADDR_WIDTH  data address, stable while d_req
d_data_write  in  DATA_WIDTH  store data
d_data_wstrb  in  DATA_WIDTH/8  byte strobes for store
d_write_enable  in  1  1 = store, 0 = load; stable while d_req
d_data_read  out  DATA_WIDTH  load data
d_data_valid  out  1  one-cycle load/store completion pulse
m_req  out  1  memory access strobe, one cycle per access
m_address  out  ADDR_WIDTH  memory address
m_data_write  out  DATA_WIDTH  memory write data
m_data_wstrb  out  DATA_WIDTH/8  memory byte strobes
m_write_enable  out  1  memory write, valid only with m_req
m_data_read  in  DATA_WIDTH  memory read data
m_data_valid  in  1  memory read completion, latency >=1 cycle after m_req

Behaviour:
- FSM states: IDLE, I_WAIT, D_WAIT, D_WACK.
- Reset (async, any state): state=IDLE, streak counter=0. m_req, m_write_enable, i_data_valid and d_data_valid are 0. m_address, m_data_write, m_data_wstrb, i_data_read and d_data_read are 0.
- IDLE arbitration, combinational within the cycle:
  - Data wins if d_req && !(i_req && streak==MAX_D_BURST).
  - Otherwise instruction wins if i_req.
  - Otherwise no grant.
- Issue cycle (in IDLE with a grant): m_req=1, and m_address/m_data_write/m_data_wstrb/m_write_enable are muxed from the winner. m_write_enable=0 for fetches. Next state:
  - fetch -> I_WAIT
  - load -> D_WAIT
  - store -> D_WACK
- I_WAIT: m_req=0.
  - m_data_valid -> i_data_valid=1 and i_data_read=m_data_read in the same cycle (combinational forward, no added latency), then -> IDLE.
  - i_data_read is 0 outside the valid cycle.
- D_WAIT: same as I_WAIT but drives d_data_valid/d_data_read.
- D_WACK: the store was accepted at the issue edge. d_data_valid=1 for exactly one cycle, d_data_read=0, -> IDLE.
- Back-to-back throughput:
  - A requester deasserts req at the edge after its valid pulse, so the earliest re-grant is the cycle after the return to IDLE.
  - Load: 3 cycles minimum (issue, valid, idle). Store: 2 cycles plus idle.
- Streak counter:
  - Increments on each data grant while i_req=1, saturating at MAX_D_BURST.
  - Clears on any instruction grant, or whenever i_req=0 in IDLE.
- m_data_valid in IDLE or D_WACK is ignored: no output pulse, no state change.
- Simultaneous i_req and d_req with streak<MAX_D_BURST: data granted, instruction waits.
- Reset mid-transaction (I_WAIT/D_WAIT): the transaction is dropped and no valid pulse is ever produced. A late m_data_valid after reset is ignored per the rule above.
- Request signals changing while not granted are legal. Address and data are sampled only in the issue cycle.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, I_WAIT, D_WAIT, D_WACK) and grant enum (GNT_NONE, GNT_I, GNT_D).
- Single module. The arbitration and streak logic is small enough that a sub-module is not warranted.

Test Plan:
1. reset_n=0 for 2 cycles, then 1 -> all outputs 0, m_req stays 0 with no requests.
2. i_req, i_address=0x40; memory returns 0x00000013 one cycle after m_req -> m_req with m_address=0x40 for 1 cycle; i_data_valid 1-cycle pulse with i_data_read=0x13; d_data_valid stays 0.
3. i_req and d_req (load 0x100) rise the same cycle -> first m_address=0x100 and d_data_valid first; next issue is 0x40 fetch, then i_data_valid.
4. Store d_address=0x200, data 0xDEADBEEF, wstrb 4'b0011 -> one cycle of m_req=1, m_write_enable=1, m_data_wstrb=0011; d_data_valid the next cycle; no m_data_valid needed.
5. MAX_D_BURST=4, d_req re-asserted after every completion, i_req held -> four data grants, fifth grant fetch, then data resumes.
6. Reset asserted during I_WAIT, m_data_valid pulsed 2 cycles after release -> i_data_valid and d_data_valid never assert; state stays IDLE.
